rv32_run_trace: RTL and testbench

Parametrised run-control and commit-trace unit for the single-cycle RV32 core. It gates the core with a clock enable for a programmed number of cycles, or until a stop/trigger condition, and captures each committed instruction's PC, instruction word, register write and store into a circular trace buffer. The captured entries are drained oldest-first over a valid/ready port. It sits beside the core and replaces fixed-length, print-based run observation with a reusable, synthesizable block.

---
 rtl/run_trace_pkg.sv | 29 ++
 rtl/trace_ring.sv | 69 ++++++
 rtl/rv32_run_trace.sv | 197 +++++++++++++++++++
 tb/tb_rv32_run_trace.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_trace_pkg.sv
// rtl/run_trace_pkg.sv - shared types for the RV32 run-control and commit-trace unit
package run_trace_pkg;

  localparam int unsigned TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    TRIG_NONE,
    TRIG_PC,
    TRIG_RD,
    TRIG_STORE
  } trig_mode_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] insn;
    logic                  rd_we;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] rd_data;
    logic                  mem_we;
    logic [TRACE_XLEN-1:0] mem_addr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - circular commit buffer; a push into a full ring drops the oldest entry
module trace_ring
  import run_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  trace_entry_t             push_data,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop_ok;
  logic          overwrite;

  assign full      = (count == FULL_CNT);
  assign pop_ok    = pop && (count != '0);
  assign overwrite = push && full && !pop_ok;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Overwrite keeps count at DEPTH and drags the read pointer along with the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok || overwrite) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop_ok && !full) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push) begin
        count <= count - 1'b1;
      end
      if (overwrite) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_run_trace.sv
// rtl/rv32_run_trace.sv - gates the core for a bounded or triggered run and records its commits
module rv32_run_trace
  import run_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int PT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             run_stop,
  input  logic [1:0]       trig_mode,
  input  logic [XLEN-1:0]  trig_pc,
  input  logic [4:0]       trig_rd,
  input  logic [PT_W-1:0]  post_trig,
  output logic             cpu_en,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  commit_insn,
  input  logic [XLEN-1:0]  commit_rd_data,
  input  logic [XLEN-1:0]  commit_mem_addr,
  input  logic             commit_rd_we,
  input  logic             commit_mem_we,
  input  logic [4:0]       commit_rd,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [XLEN-1:0]  rd_pc,
  output logic [XLEN-1:0]  rd_insn,
  output logic [XLEN-1:0]  rd_rd_data,
  output logic [XLEN-1:0]  rd_mem_addr,
  output logic             rd_rd_we,
  output logic             rd_mem_we,
  output logic [4:0]       rd_rd,
  output logic             busy,
  output logic             done,
  output logic             triggered,
  output logic             overflow,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int AW = $clog2(DEPTH);

  state_e           state;
  state_e           state_nxt;
  trig_mode_e       mode_q;
  logic [XLEN-1:0]  trig_pc_q;
  logic [4:0]       trig_rd_q;
  logic [PT_W-1:0]  post_len_q;
  logic [PT_W-1:0]  post_cnt;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q;
  logic             trig_q;
  logic             start;
  logic             capture;
  logic             match;
  logic             limit_hit;
  logic             post_hit;
  logic             halt;
  logic             pop;
  trace_entry_t     push_data;
  trace_entry_t     head;
  logic [AW:0]      count;
  logic             ring_ovf;

  assign start   = (state == IDLE) && run_start;
  assign capture = (state == RUN) && commit_valid;
  assign pop     = (state == HALT) && rd_ready;

  assign push_data = '{pc: commit_pc, insn: commit_insn, rd_we: commit_rd_we, rd: commit_rd,
                       rd_data: commit_rd_data, mem_we: commit_mem_we, mem_addr: commit_mem_addr};

  // Only the first captured match arms the post-trigger countdown.
  always_comb begin
    match = 1'b0;
    if (capture && !trig_q) begin
      case (mode_q)
        TRIG_PC:    match = (commit_pc == trig_pc_q);
        TRIG_RD:    match = commit_rd_we && (commit_rd == trig_rd_q) && (commit_rd != 5'd0);
        TRIG_STORE: match = commit_mem_we;
        default:    match = 1'b0;
      endcase
    end
  end

  assign cnt_inc   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
  assign limit_hit = (run_len_q != '0) && (cnt_inc == run_len_q);
  assign post_hit  = (match && (post_len_q == '0)) ||
                     (capture && trig_q && (post_cnt == PT_W'(1)));
  assign halt      = (state == RUN) && (run_stop || limit_hit || post_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_start) state_nxt = RUN;
      RUN:     if (halt) state_nxt = HALT;
      HALT:    if (count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trace data is forced to zero whenever no entry is being offered.
  always_comb begin
    cpu_en      = 1'b0;
    busy        = 1'b0;
    rd_valid    = 1'b0;
    rd_pc       = '0;
    rd_insn     = '0;
    rd_rd_data  = '0;
    rd_mem_addr = '0;
    rd_rd_we    = 1'b0;
    rd_mem_we   = 1'b0;
    rd_rd       = '0;
    case (state)
      RUN: begin
        cpu_en = 1'b1;
        busy   = 1'b1;
      end
      HALT:    rd_valid = (count != '0);
      default: ;
    endcase
    if (rd_valid) begin
      rd_pc       = head.pc;
      rd_insn     = head.insn;
      rd_rd_data  = head.rd_data;
      rd_mem_addr = head.mem_addr;
      rd_rd_we    = head.rd_we;
      rd_mem_we   = head.mem_we;
      rd_rd       = head.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      run_len_q  <= '0;
      mode_q     <= TRIG_NONE;
      trig_pc_q  <= '0;
      trig_rd_q  <= '0;
      post_len_q <= '0;
      post_cnt   <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (start) begin
      cycle_cnt  <= '0;
      run_len_q  <= run_cycles;
      mode_q     <= trig_mode_e'(trig_mode);
      trig_pc_q  <= trig_pc;
      trig_rd_q  <= trig_rd;
      post_len_q <= post_trig;
      post_cnt   <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (state == RUN) begin
      cycle_cnt <= cnt_inc;
      if (match) begin
        trig_q   <= 1'b1;
        post_cnt <= post_len_q;
      end else if (capture && trig_q) begin
        post_cnt <= post_cnt - 1'b1;
      end
      if (halt) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign triggered = trig_q;
  assign overflow  = ring_ovf;

  trace_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .overflow  (ring_ovf)
  );

endmodule

// File: tb/tb_rv32_run_trace.sv
// tb/tb_rv32_run_trace.sv - bench for rv32_run_trace: queue-based reference plus directed runs
module tb_rv32_run_trace;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int PT_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run_start = 1'b0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic             run_stop = 1'b0;
  logic [1:0]       trig_mode = '0;
  logic [XLEN-1:0]  trig_pc = '0;
  logic [4:0]       trig_rd = '0;
  logic [PT_W-1:0]  post_trig = '0;
  logic             cpu_en;
  logic             commit_valid = 1'b0;
  logic [XLEN-1:0]  commit_pc = '0;
  logic [XLEN-1:0]  commit_insn = '0;
  logic [XLEN-1:0]  commit_rd_data = '0;
  logic [XLEN-1:0]  commit_mem_addr = '0;
  logic             commit_rd_we = 1'b0;
  logic             commit_mem_we = 1'b0;
  logic [4:0]       commit_rd = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic [XLEN-1:0]  rd_pc, rd_insn, rd_rd_data, rd_mem_addr;
  logic             rd_rd_we, rd_mem_we;
  logic [4:0]       rd_rd;
  logic             busy, done, triggered, overflow;
  logic [CNT_W-1:0] cycle_cnt;

  int vecs = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_run_trace #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .PT_W(PT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .run_cycles(run_cycles),
    .run_stop(run_stop), .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_rd(trig_rd),
    .post_trig(post_trig), .cpu_en(cpu_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_insn(commit_insn), .commit_rd_data(commit_rd_data),
    .commit_mem_addr(commit_mem_addr), .commit_rd_we(commit_rd_we),
    .commit_mem_we(commit_mem_we), .commit_rd(commit_rd), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_insn(rd_insn), .rd_rd_data(rd_rd_data),
    .rd_mem_addr(rd_mem_addr), .rd_rd_we(rd_rd_we), .rd_mem_we(rd_mem_we), .rd_rd(rd_rd),
    .busy(busy), .done(done), .triggered(triggered), .overflow(overflow),
    .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a run is a list of captured commits; the buffer is the last DEPTH of them.
  typedef struct {
    logic [31:0] pc, insn, rd_data, mem_addr;
    logic        rd_we, mem_we;
    logic [4:0]  rd;
  } ent_t;

  ent_t             m_q[$];
  ent_t             m_e;
  ent_t             c_h;
  bit               m_run, m_halt, m_done, m_trig, m_ovf, m_stop, m_hit, c_v;
  logic [CNT_W-1:0] m_cnt, l_len;
  logic [31:0]      l_pc;
  logic [4:0]       l_rd;
  int               l_mode, l_post, m_post;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_run = 0; m_halt = 0; m_done = 0; m_trig = 0; m_ovf = 0;
      m_cnt = '0; m_post = 0;
    end else if (m_run) begin
      m_stop = run_stop;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (l_len != 0 && m_cnt == l_len) m_stop = 1;
      if (commit_valid) begin
        m_e.pc = commit_pc; m_e.insn = commit_insn; m_e.rd_data = commit_rd_data;
        m_e.mem_addr = commit_mem_addr; m_e.rd_we = commit_rd_we;
        m_e.mem_we = commit_mem_we; m_e.rd = commit_rd;
        m_q.push_back(m_e);
        if (m_q.size() > DEPTH) begin
          m_q.delete(0);
          m_ovf = 1;
        end
        case (l_mode)
          1: m_hit = (commit_pc == l_pc);
          2: m_hit = commit_rd_we && (commit_rd == l_rd) && (commit_rd != 0);
          3: m_hit = commit_mem_we;
          default: m_hit = 0;
        endcase
        if (!m_trig && m_hit) begin
          m_trig = 1;
          m_post = l_post;
          if (l_post == 0) m_stop = 1;
        end else if (m_trig) begin
          m_post--;
          if (m_post == 0) m_stop = 1;
        end
      end
      if (m_stop) begin
        m_run = 0; m_halt = 1; m_done = 1;
      end
    end else if (m_halt) begin
      if (m_q.size() == 0) m_halt = 0;
      else if (rd_ready) m_q.delete(0);
    end else if (run_start) begin
      m_q.delete();
      m_run = 1; m_done = 0; m_trig = 0; m_ovf = 0; m_cnt = '0;
      l_len = run_cycles; l_mode = int'(trig_mode); l_pc = trig_pc;
      l_rd = trig_rd; l_post = int'(post_trig);
    end
  end

  always @(negedge clk) begin
    c_v = m_halt && (m_q.size() != 0);
    if (c_v) c_h = m_q[0];
    else begin
      c_h.pc = 0; c_h.insn = 0; c_h.rd_data = 0; c_h.mem_addr = 0;
      c_h.rd_we = 0; c_h.mem_we = 0; c_h.rd = 0;
    end
    check("cpu_en", cpu_en, m_run);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("triggered", triggered, m_trig);
    check("overflow", overflow, m_ovf);
    check("cycle_cnt", cycle_cnt, m_cnt);
    check("rd_valid", rd_valid, c_v);
    check("rd_pc", rd_pc, c_h.pc);
    check("rd_insn", rd_insn, c_h.insn);
    check("rd_rd_data", rd_rd_data, c_h.rd_data);
    check("rd_mem_addr", rd_mem_addr, c_h.mem_addr);
    check("rd_rd_we", rd_rd_we, c_h.rd_we);
    check("rd_mem_we", rd_mem_we, c_h.mem_we);
    check("rd_rd", rd_rd, c_h.rd);
  end

  // Core stand-in: commit n has PC 4n, writes x(n%8), stores when n%7==3.
  int          n;
  int          stop_at;
  bit          restart;
  int          en_cycles;
  logic [31:0] drained[$];

  task automatic step();
    if (cpu_en) begin
      en_cycles++;
      commit_valid    = 1'b1;
      commit_pc       = n * 4;
      commit_insn     = 32'h13 | (n << 7);
      commit_rd       = 5'(n % 8);
      commit_rd_we    = 1'b1;
      commit_rd_data  = n * 3 + 1;
      commit_mem_we   = (n % 7 == 3);
      commit_mem_addr = 32'h1000 + n * 4;
      run_stop        = (n == stop_at);
      run_start       = restart && (n == 2);
      n++;
    end else begin
      commit_valid = 1'b0;
      run_stop     = 1'b0;
      run_start    = 1'b0;
    end
    if (rd_valid && rd_ready) drained.push_back(rd_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int len, input int mode, input logic [31:0] tpc, input int trd,
                        input int post, input int stp, input bit rs);
    int  c;
    bit  seen;
    stop_at = stp; restart = rs; n = 0; en_cycles = 0;
    drained.delete();
    run_cycles = CNT_W'(len); trig_mode = 2'(mode); trig_pc = tpc;
    trig_rd = 5'(trd); post_trig = PT_W'(post);
    run_start = 1'b1;
    @(posedge clk);
    #1;
    run_start = 1'b0;
    if (rs) run_cycles = 16'd3;
    seen = 0;
    c = 0;
    while (!(seen && !cpu_en && !rd_valid) && c < 1000) begin
      if (cpu_en) seen = 1;
      step();
      c++;
    end
    check("run_completes", c < 1000, 1);
    step();
    step();
  endtask

  initial begin
    stop_at = -1; restart = 0; n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cpu_en", cpu_en, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    step();

    // 10-cycle bounded run, no trigger
    do_run(10, 0, 0, 0, 0, -1, 0);
    check("t1_en_cycles", en_cycles, 10);
    check("t1_cycle_cnt", cycle_cnt, 10);
    check("t1_count", drained.size(), 10);
    check("t1_first_pc", drained[0], 32'h0);
    check("t1_last_pc", drained[9], 32'h24);
    check("t1_overflow", overflow, 0);
    check("t1_done", done, 1);

    // 20 commits into 16 entries: commits 5..20 survive
    do_run(20, 0, 0, 0, 0, -1, 0);
    check("t2_overflow", overflow, 1);
    check("t2_count", drained.size(), 16);
    check("t2_first_pc", drained[0], 32'h10);
    check("t2_last_pc", drained[15], 32'h4C);
    check("t2_cycle_cnt", cycle_cnt, 20);

    // PC trigger at 0x18 with two post-trigger captures
    do_run(0, 1, 32'h18, 0, 2, -1, 0);
    check("t3_triggered", triggered, 1);
    check("t3_count", drained.size(), 9);
    check("t3_last_pc", drained[8], 32'h20);
    check("t3_cycle_cnt", cycle_cnt, 9);

    // x0 writes never trigger
    do_run(12, 2, 0, 0, 0, -1, 0);
    check("t4a_triggered", triggered, 0);
    check("t4a_cycle_cnt", cycle_cnt, 12);

    // first x5 write halts immediately when post_trig=0
    do_run(0, 2, 0, 5, 0, -1, 0);
    check("t4b_triggered", triggered, 1);
    check("t4b_count", drained.size(), 6);
    check("t4b_last_pc", drained[5], 32'h14);

    // store trigger, one more capture
    do_run(0, 3, 0, 0, 1, -1, 0);
    check("t5_triggered", triggered, 1);
    check("t5_last_pc", drained[$], 32'h10);
    check("t5_count", drained.size(), 5);

    // run_stop coincides with the length limit; a mid-run run_start is ignored
    do_run(6, 0, 0, 0, 0, 5, 1);
    check("t6_cycle_cnt", cycle_cnt, 6);
    check("t6_count", drained.size(), 6);
    check("t6_done", done, 1);

    // reset in the middle of a free run
    n = 0; stop_at = -1; restart = 0;
    run_cycles = '0; trig_mode = 2'd0;
    run_start = 1'b1;
    @(posedge clk);
    #1;
    run_start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_cpu_en", cpu_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    do_run(10, 0, 0, 0, 0, -1, 0);
    check("t7_cycle_cnt", cycle_cnt, 10);
    check("t7_count", drained.size(), 10);
    check("t7_last_pc", drained[9], 32'h24);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
    $finish;
  end

endmodule
